// File: rtl/state_dump_unit_pkg.sv
// Shared widths, stream kind encodings and dump FSM states
// for the post-halt state dump unit.
package state_dump_unit_pkg;

    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int MEM_WORDS = 16;
    localparam int MEM_BASE  = 0;
    localparam int DM_AW     = 8;
    localparam int RF_AW     = 5;
    localparam int IDX_W     = 8;

    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RF    = 2'd1,
        ST_DM    = 2'd2,
        ST_DRAIN = 2'd3
    } dump_state_t;

endpackage

// File: rtl/state_dump_unit_beat_reg.sv
// Single-entry valid/ready output register for dump beats.
// Loads whenever empty or being drained, so the stream has no bubbles.
module dump_beat_reg
    import state_dump_unit_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_item_valid,
    input  logic [XLEN-1:0]  i_data,
    input  logic             i_kind,
    input  logic [IDX_W-1:0] i_index,
    input  logic             i_last,
    input  logic             i_ready,
    output logic             o_load,
    output logic             o_valid,
    output logic [XLEN-1:0]  o_data,
    output logic             o_kind,
    output logic [IDX_W-1:0] o_index,
    output logic             o_last
);

    logic             r_valid;
    logic [XLEN-1:0]  r_data;
    logic             r_kind;
    logic [IDX_W-1:0] r_index;
    logic             r_last;
    logic             w_load;

    assign w_load = i_item_valid && (!r_valid || i_ready);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_kind  <= 1'b0;
            r_index <= '0;
            r_last  <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_kind  <= i_kind;
            r_index <= i_index;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_load  = w_load;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_kind  = r_kind;
    assign o_index = r_index;
    assign o_last  = r_last;

endmodule

// File: rtl/state_dump_unit.sv
// Walks the register file then a data-memory window over the debug
// read ports and streams each word out as one valid/ready beat.
module state_dump_unit
    import state_dump_unit_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic [RF_AW-1:0] o_dbg_rf_addr,
    input  logic [XLEN-1:0]  i_dbg_rf_data,
    output logic [DM_AW-1:0] o_dbg_dm_addr,
    input  logic [XLEN-1:0]  i_dbg_dm_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [XLEN-1:0]  o_out_data,
    output logic             o_out_kind,
    output logic [7:0]       o_out_index,
    output logic             o_out_last,
    output logic             o_busy,
    output logic             o_done
);

    dump_state_t      r_state;
    dump_state_t      w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_done;
    logic             w_done_nxt;

    logic             w_item_valid;
    logic             w_load;
    logic [XLEN-1:0]  w_data;
    logic             w_kind;
    logic [IDX_W-1:0] w_index;
    logic             w_last;
    logic [DM_AW-1:0] w_dm_addr;
    logic             w_out_valid;

    // Memory window address wraps naturally at DM_AW bits.
    assign w_dm_addr    = DM_AW'(MEM_BASE) + DM_AW'(r_idx);
    assign w_item_valid = (r_state == ST_RF) || (r_state == ST_DM);

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_done_nxt    = r_done;
        w_data        = '0;
        w_kind        = KIND_REG;
        w_index       = '0;
        w_last        = 1'b0;
        o_dbg_rf_addr = '0;
        o_dbg_dm_addr = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_RF;
                    w_idx_nxt   = '0;
                    w_done_nxt  = 1'b0;
                end
            end
            ST_RF: begin
                o_dbg_rf_addr = RF_AW'(r_idx);
                w_data        = i_dbg_rf_data;
                w_kind        = KIND_REG;
                w_index       = r_idx;
                if (w_load) begin
                    if (r_idx == IDX_W'(NREGS - 1)) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_DM;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            ST_DM: begin
                o_dbg_dm_addr = w_dm_addr;
                w_data        = i_dbg_dm_data;
                w_kind        = KIND_MEM;
                w_index       = IDX_W'(w_dm_addr);
                w_last        = (r_idx == IDX_W'(MEM_WORDS - 1));
                if (w_load) begin
                    if (w_last) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_out_valid && i_out_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    dump_beat_reg u_beat (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_item_valid (w_item_valid),
        .i_data       (w_data),
        .i_kind       (w_kind),
        .i_index      (w_index),
        .i_last       (w_last),
        .i_ready      (i_out_ready),
        .o_load       (w_load),
        .o_valid      (w_out_valid),
        .o_data       (o_out_data),
        .o_kind       (o_out_kind),
        .o_index      (o_out_index),
        .o_last       (o_out_last)
    );

    assign o_out_valid = w_out_valid;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;

endmodule

// File: tb/tb_state_dump_unit.sv
// Directed bench for state_dump_unit: full dumps under back-pressure,
// ignored restarts, mid-dump reset and repeat dumps.
module tb_state_dump_unit;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic [4:0]  dbg_rf_addr;
    logic [31:0] dbg_rf_data;
    logic [7:0]  dbg_dm_addr;
    logic [31:0] dbg_dm_data;
    logic        out_valid;
    logic        i_out_ready;
    logic [31:0] out_data;
    logic        out_kind;
    logic [7:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] rf  [32];
    logic [31:0] ram [256];

    int n_assert = 0;
    int n_fail   = 0;

    state_dump_unit dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .o_dbg_rf_addr (dbg_rf_addr),
        .i_dbg_rf_data (dbg_rf_data),
        .o_dbg_dm_addr (dbg_dm_addr),
        .i_dbg_dm_data (dbg_dm_data),
        .o_out_valid   (out_valid),
        .i_out_ready   (i_out_ready),
        .o_out_data    (out_data),
        .o_out_kind    (out_kind),
        .o_out_index   (out_index),
        .o_out_last    (out_last),
        .o_busy        (busy),
        .o_done        (done)
    );

    assign dbg_rf_data = rf[dbg_rf_addr];
    assign dbg_dm_data = ram[dbg_dm_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {kind, index, last, data} of beat b for the standard preload
    function automatic logic [41:0] exp_beat(input int b);
        logic        k;
        logic [7:0]  ix;
        logic        l;
        logic [31:0] d;
        if (b < 32) begin
            k  = 1'b0;
            ix = 8'(b);
            l  = 1'b0;
            d  = (b == 0) ? 32'h0 : 32'h100 + 32'(b);
        end else begin
            k  = 1'b1;
            ix = 8'(b - 32);
            l  = (b == 47);
            d  = 32'hA0 + 32'(b - 32);
        end
        return {k, ix, l, d};
    endfunction

    task automatic do_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_done_clr", 64'(done), 64'd0);
        chk("start_valid_lat", 64'(out_valid), 64'd0);
    endtask

    // mode 0: ready always; mode 1: ready 1 cycle in 3
    task automatic collect(input int mode, input int restart_at,
                           input int stall_last, input int abort_at);
        int  got;
        int  cyc;
        int  stalls;
        bit  restarted;
        bit  fin;
        bit  ready;
        got       = 0;
        cyc       = 0;
        stalls    = 0;
        restarted = 1'b0;
        fin       = 1'b0;
        while (!fin && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            i_start = 1'b0;
            if (i_rst) begin
                i_rst = 1'b0;
                chk("rst_valid", 64'(out_valid), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_done", 64'(done), 64'd0);
                fin = 1'b1;
            end else begin
                if (cyc == 1)
                    chk("first_valid", 64'(out_valid), 64'd1);
                if (mode == 0)
                    chk("no_bubble", 64'(out_valid), 64'd1);
                if (out_valid)
                    chk($sformatf("beat%0d", got),
                        64'({out_kind, out_index, out_last, out_data}),
                        64'(exp_beat(got)));
                ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
                if (out_valid && out_last && stalls < stall_last) begin
                    ready = 1'b0;
                    stalls++;
                    chk("stall_busy", 64'(busy), 64'd1);
                    chk("stall_done", 64'(done), 64'd0);
                end
                if (restart_at >= 0 && got == restart_at && !restarted
                    && out_valid) begin
                    i_start   = 1'b1;
                    restarted = 1'b1;
                end
                i_out_ready = ready;
                if (abort_at >= 0 && got == abort_at && out_valid) begin
                    i_rst = 1'b1;
                end else if (out_valid && ready) begin
                    got++;
                    if (got == 48) begin
                        @(negedge clk);
                        i_start = 1'b0;
                        chk("end_done", 64'(done), 64'd1);
                        chk("end_busy", 64'(busy), 64'd0);
                        chk("end_valid", 64'(out_valid), 64'd0);
                        fin = 1'b1;
                    end
                end
            end
        end
        i_start     = 1'b0;
        i_out_ready = 1'b1;
        if (!fin)
            chk("timeout_beats", 64'(got), 64'd48);
    endtask

    initial begin
        for (int k = 0; k < 32; k++)
            rf[k] = (k == 0) ? 32'h0 : 32'h100 + 32'(k);
        for (int k = 0; k < 256; k++)
            ram[k] = (k < 16) ? 32'hA0 + 32'(k) : 32'hDEAD_0000 + 32'(k);

        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_out_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_rf_addr", 64'(dbg_rf_addr), 64'd0);
        chk("reset_dm_addr", 64'(dbg_dm_addr), 64'd0);
        chk("reset_data", 64'(out_data), 64'd0);
        i_rst   = 1'b0;
        i_start = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // full-rate dump
        do_start();
        collect(0, -1, 0, -1);

        // ready 1 cycle in 3
        do_start();
        collect(1, -1, 0, -1);

        // start during dump ignored
        do_start();
        collect(0, 10, 0, -1);

        // reset mid-dump, then a fresh full dump
        do_start();
        collect(0, -1, 0, 20);
        do_start();
        collect(0, -1, 0, -1);

        // last beat stalled 5 cycles
        do_start();
        collect(0, -1, 5, -1);

        // repeat dump after done
        chk("pre_done", 64'(done), 64'd1);
        do_start();
        collect(0, -1, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
